// File: rtl/mips_fetch_pkg.sv
// ============================================================================
// Module      : mips_fetch_pkg
// Description : Shared fetch-stage types, reset defaults and opcode field bounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2,
    S_HOLD = 2'd3
  } fetchState_t;

  localparam logic [31:0] c_resetPcDefault  = 32'h0040_0000;
  localparam logic [31:0] c_nopWordDefault  = 32'h0000_0000;
  localparam int          c_opMsb           = 31;
  localparam int          c_opLsb           = 26;

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register with flush > stall > load > bubble priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_register
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = c_nopWordDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] loadInstr,
  input  logic [31:0] loadPcPlus4,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pcPlus4;

  // Flush and bubble both keep pc_plus4 so downstream sees a stable value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_WORD;
      r_pcPlus4 <= 32'h0000_0000;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_WORD;
    end else if (stall) begin
      r_valid   <= r_valid;
    end else if (load) begin
      r_valid   <= 1'b1;
      r_instr   <= loadInstr;
      r_pcPlus4 <= loadPcPlus4;
    end else begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_WORD;
    end
  end

  assign ifid_valid    = r_valid;
  assign ifid_instr    = r_instr;
  assign ifid_pc_plus4 = r_pcPlus4;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : PC and single-outstanding-request fetch FSM feeding IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_resetPcDefault,
  parameter logic [31:0] NOP_WORD = c_nopWordDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic [5:0]  ifid_op,
  output logic        fetch_err
);

  fetchState_t r_state;
  fetchState_t w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic [31:0] r_holdBuf;
  logic [31:0] w_holdBufNext;
  logic [31:0] w_redirectAligned;
  logic [31:0] w_pcPlus4;
  logic        w_load;
  logic [31:0] w_loadInstr;
  logic        r_fetchErr;

  assign w_redirectAligned = {redirect_pc[31:2], 2'b00};
  assign w_pcPlus4         = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_holdBuf  <= 32'h0000_0000;
      r_fetchErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_holdBuf  <= w_holdBufNext;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00))
        r_fetchErr <= 1'b1;
    end
  end

  // Every state honours a redirect by retargeting the PC; only the exit differs.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_holdBufNext = r_holdBuf;
    w_load        = 1'b0;
    w_loadInstr   = imem_rdata;
    case (r_state)
      S_REQ: begin
        if (redirect_valid)  w_pcNext    = w_redirectAligned;
        else if (imem_ready) w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            w_pcNext    = w_redirectAligned;
            w_stateNext = S_REQ;
          end else if (stall) begin
            w_holdBufNext = imem_rdata;
            w_stateNext   = S_HOLD;
          end else begin
            w_load      = 1'b1;
            w_pcNext    = w_pcPlus4;
            w_stateNext = S_REQ;
          end
        end else if (redirect_valid) begin
          w_pcNext    = w_redirectAligned;
          w_stateNext = S_KILL;
        end
      end
      S_KILL: begin
        if (redirect_valid) w_pcNext    = w_redirectAligned;
        if (imem_rvalid)    w_stateNext = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_holdBufNext = 32'h0000_0000;
          w_pcNext      = w_redirectAligned;
          w_stateNext   = S_REQ;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_loadInstr = r_holdBuf;
          w_pcNext    = w_pcPlus4;
          w_stateNext = S_REQ;
        end
      end
      default: w_stateNext = S_REQ;
    endcase
  end

  assign imem_req  = (r_state == S_REQ) && !redirect_valid && !reset;
  assign imem_addr = r_pc;
  assign fetch_err = r_fetchErr;
  assign ifid_op   = ifid_instr[c_opMsb:c_opLsb];

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_ifId (
    .clk           (clk),
    .reset         (reset),
    .flush         (redirect_valid),
    .stall         (stall),
    .load          (w_load),
    .loadInstr     (w_loadInstr),
    .loadPcPlus4   (w_pcPlus4),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4)
  );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic [5:0]  ifid_op;
  logic        fetch_err;

  int evaluated = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_op        (ifid_op),
    .fetch_err      (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step(); step();
    check("rst_req",     {31'd0, imem_req},   32'd0);
    check("rst_addr",    imem_addr,           32'h0040_0000);
    check("rst_valid",   {31'd0, ifid_valid}, 32'd0);
    check("rst_instr",   ifid_instr,          32'h0000_0000);
    check("rst_pcp4",    ifid_pc_plus4,       32'd0);
    check("rst_err",     {31'd0, fetch_err},  32'd0);

    // First fetch: accept, then rvalid the next cycle
    reset = 1'b0; imem_ready = 1'b1;
    #1;
    check("f1_req",  {31'd0, imem_req}, 32'd1);
    check("f1_addr", imem_addr,         32'h0040_0000);
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    #1;
    check("f1_wait_req", {31'd0, imem_req},   32'd0);
    check("f1_notyet",   {31'd0, ifid_valid}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    check("f1_valid", {31'd0, ifid_valid}, 32'd1);
    check("f1_op",    {26'd0, ifid_op},    32'h0000_0008);
    check("f1_instr", ifid_instr,          32'h2008_0005);
    check("f1_pcp4",  ifid_pc_plus4,       32'h0040_0004);
    check("f1_next",  imem_addr,           32'h0040_0004);

    // rvalid while in S_REQ is ignored
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("ign_valid", {31'd0, ifid_valid}, 32'd0);
    check("ign_addr",  imem_addr,           32'h0040_0004);
    check("ign_pcp4",  ifid_pc_plus4,       32'h0040_0004);

    // Stall for three edges while data returns
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C09_0010; stall = 1'b1;
    step();
    imem_rvalid = 1'b0;
    check("hold1_valid", {31'd0, ifid_valid}, 32'd0);
    check("hold1_req",   {31'd0, imem_req},   32'd0);
    step();
    check("hold2_instr", ifid_instr,        32'h0000_0000);
    check("hold2_req",   {31'd0, imem_req}, 32'd0);
    step();
    check("hold3_req",  {31'd0, imem_req}, 32'd0);
    check("hold3_addr", imem_addr,         32'h0040_0004);
    stall = 1'b0;
    step();
    check("hold_valid", {31'd0, ifid_valid}, 32'd1);
    check("hold_instr", ifid_instr,          32'h8C09_0010);
    check("hold_pcp4",  ifid_pc_plus4,       32'h0040_0008);
    check("hold_addr",  imem_addr,           32'h0040_0008);
    check("hold_req",   {31'd0, imem_req},   32'd1);

    // Redirect while waiting; stale data arrives later and is discarded
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    #1;
    check("kill_req_redir", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    check("kill_flush_v", {31'd0, ifid_valid}, 32'd0);
    check("kill_flush_i", ifid_instr,          32'h0000_0000);
    check("kill_req",     {31'd0, imem_req},   32'd0);
    step();
    check("kill_bubble", {31'd0, ifid_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    step();
    imem_rvalid = 1'b0;
    check("kill_disc_v", {31'd0, ifid_valid}, 32'd0);
    check("kill_disc_i", ifid_instr,          32'h0000_0000);
    check("kill_addr",   imem_addr,           32'h0040_0100);
    check("kill_req2",   {31'd0, imem_req},   32'd1);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0800_0040;
    step();
    imem_rvalid = 1'b0;
    check("wrap_valid", {31'd0, ifid_valid}, 32'd1);
    check("wrap_op",    {26'd0, ifid_op},    32'h0000_0002);
    check("wrap_pcp4",  ifid_pc_plus4,       32'h0000_0000);
    check("wrap_addr",  imem_addr,           32'h0000_0000);

    // Redirect and stall together flush a valid IF/ID
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0200; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("rs_valid", {31'd0, ifid_valid}, 32'd0);
    check("rs_instr", ifid_instr,          32'h0000_0000);
    check("rs_addr",  imem_addr,           32'h0040_0200);

    // Misaligned redirect: sticky error, aligned PC
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
    #1;
    check("err_pre", {31'd0, fetch_err}, 32'd0);
    step();
    redirect_valid = 1'b0;
    check("err_set",  {31'd0, fetch_err}, 32'd1);
    check("err_addr", imem_addr,          32'h0040_0100);
    step(); step();
    check("err_sticky", {31'd0, fetch_err}, 32'd1);

    // Reset abandons an outstanding request and clears the error
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; reset = 1'b1;
    #1;
    check("rst2_req0", {31'd0, imem_req}, 32'd0);
    step();
    check("rst2_err",   {31'd0, fetch_err},  32'd0);
    check("rst2_addr",  imem_addr,           32'h0040_0000);
    check("rst2_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst2_pcp4",  ifid_pc_plus4,       32'd0);
    check("rst2_req",   {31'd0, imem_req},   32'd0);
    reset = 1'b0;
    #1;
    check("rst2_rel_req", {31'd0, imem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0040_0000, first fetch address after reset.
REQ-002 SHALL provide parameter NOP_WORD, default 32'h0000_0000, instruction word loaded into IF/ID on flush or bubble.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hazard unit hold request: freeze PC and IF/ID.
REQ-006 redirect_valid  in  1  taken branch (BranchEQ/BranchNE) or jump (J) resolved in decode.
REQ-007 redirect_pc  in  32  branch or jump target.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  word address of the request; equals pc.
REQ-010 imem_ready  in  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  in  1  read data valid.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-014 ifid_instr  out  32  IF/ID instruction.
REQ-015 ifid_pc_plus4  out  32  IF/ID fetch address + 4.
REQ-016 ifid_op  out  6  ifid_instr[31:26], the opcode driven into the control unit.
REQ-017 fetch_err  out  1  sticky flag: a misaligned redirect was received.

Function
REQ-018 The block SHALL keep at most one memory request outstanding; it is a 4-state FSM: S_REQ, S_WAIT, S_KILL, S_HOLD.
REQ-019 imem_req SHALL equal (state==S_REQ) && !redirect_valid && !reset.
REQ-020 S_REQ with redirect_valid: pc<=redirect_pc; stay in S_REQ. Else if imem_ready: go to S_WAIT.
REQ-021 S_WAIT with imem_rvalid and redirect_valid: discard the data; pc<=redirect_pc; go to S_REQ.
REQ-022 S_WAIT with imem_rvalid, no redirect, stall=1: capture imem_rdata into a hold buffer; go to S_HOLD.
REQ-023 S_WAIT with imem_rvalid, no redirect, stall=0: load IF/ID (valid=1, instr=imem_rdata, pc_plus4=pc+4); pc<=pc+4; go to S_REQ.
REQ-024 S_WAIT with redirect_valid and no imem_rvalid: pc<=redirect_pc; go to S_KILL.
REQ-025 S_KILL: imem_rvalid discards the data and goes to S_REQ; redirect_valid updates pc again, including when it coincides with imem_rvalid.
REQ-026 S_HOLD with redirect_valid: drop the buffer; pc<=redirect_pc; go to S_REQ. Else with stall=0: load IF/ID from the buffer; pc<=pc+4; go to S_REQ.
REQ-027 IF/ID priority: redirect_valid > stall > new load > bubble. Redirect writes valid=0, instr=NOP_WORD. Stall holds all IF/ID fields. A cycle that is not a load writes a bubble (valid=0, instr=NOP_WORD, pc_plus4 unchanged).
REQ-028 Minimum latency SHALL be 2 cycles from imem_req&&imem_ready to ifid_valid (rvalid one cycle after acceptance); peak throughput is one instruction every 2 cycles.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 If redirect_pc[1:0] != 0: set fetch_err and load pc with redirect_pc[1:0] forced to 2'b00.
REQ-031 imem_rvalid received in S_REQ or S_HOLD SHALL be ignored.

Reset
REQ-032 When reset=1 at a clock edge: pc<=RESET_PC, state<=S_REQ, ifid_valid<=0, ifid_instr<=NOP_WORD, ifid_pc_plus4<=0, fetch_err<=0, hold buffer<=0.
REQ-033 Reset SHALL override stall and redirect_valid; reset asserted mid-S_WAIT abandons the request. Instruction memory is reset on the same reset, so no stale response follows.
REQ-034 imem_req SHALL be 0 while reset=1.

Structure
REQ-035 A shared package mips_fetch_pkg SHALL hold the FSM state enumeration, the RESET_PC and NOP_WORD defaults, and the opcode field bounds (31:26).
REQ-036 The IF/ID register, with its valid/flush/stall priority, SHALL be a sub-module named if_id_register; the PC and FSM stay in the top level.

Verification
REQ-037 Reset release, memory with 1-cycle rvalid returning 32'h2008_0005 -> imem_addr=32'h0040_0000, ifid_valid=1 two cycles later, ifid_op=6'h08, ifid_pc_plus4=32'h0040_0004.
REQ-038 stall=1 for 3 cycles while rvalid arrives -> IF/ID unchanged for 3 cycles, state S_HOLD; instruction appears the cycle after stall drops, with no duplicate or lost fetch.
REQ-039 redirect_valid with redirect_pc=32'h0040_0100 in S_WAIT, rvalid 2 cycles later -> stale word discarded, next imem_addr=32'h0040_0100, ifid_valid=0 in between.
REQ-040 pc=32'hFFFF_FFFC, sequential fetch -> next imem_addr=32'h0000_0000.
REQ-041 redirect_pc=32'h0040_0102 -> fetch_err=1 and stays 1; imem_addr=32'h0040_0100; reset clears fetch_err.
REQ-042 redirect_valid and stall asserted together with a valid IF/ID -> ifid_valid=0 and ifid_instr=NOP_WORD on the next edge.
